// File: rtl/cavlc_pkg.sv
// ============================================================================
// Module : cavlc_pkg
// Brief  : Shared constants and FSM type for the CAVLC level codeword packer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cavlc_pkg;

  localparam int MAX_PREFIX     = 15;
  localparam int MAX_SUFFIX_LEN = 5;
  localparam int MAX_CW_LEN     = 21;
  localparam int ACC_W          = 48;
  localparam int OUT_W          = 16;
  localparam int IN_THRESH      = 27;

  typedef enum logic {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } packer_state_t;

endpackage

`default_nettype wire

// File: rtl/level_vlc_packer_if.sv
// ============================================================================
// Module : level_vlc_packer_if
// Brief  : Codeword input, flush and packed-word output handshakes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface level_vlc_packer_if #(
  parameter int COUNT_W = 16
);

  logic               InValid;
  logic               InReady;
  logic [3:0]         Prefix;
  logic [4:0]         Suffix;
  logic [2:0]         SuffixLen;
  logic               Flush;
  logic               FlushReady;
  logic               FlushDone;
  logic               OutValid;
  logic               OutReady;
  logic [15:0]        OutWord;
  logic               OutLast;
  logic [COUNT_W-1:0] WordCount;

  modport master (
    output InValid, Prefix, Suffix, SuffixLen, Flush, OutReady,
    input  InReady, FlushReady, FlushDone, OutValid, OutWord, OutLast, WordCount
  );

  modport slave (
    input  InValid, Prefix, Suffix, SuffixLen, Flush, OutReady,
    output InReady, FlushReady, FlushDone, OutValid, OutWord, OutLast, WordCount
  );

endinterface

`default_nettype wire

// File: rtl/level_codeword_gen.sv
// ============================================================================
// Module : level_codeword_gen
// Brief  : Builds a left-aligned prefix/'1'/suffix codeword and its length.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module level_codeword_gen
  import cavlc_pkg::*;
(
  input  logic [3:0]            prefix_i,
  input  logic [4:0]            suffix_i,
  input  logic [2:0]            suffix_len_i,
  output logic [MAX_CW_LEN-1:0] codeword_o,
  output logic [4:0]            len_o
);

  logic [2:0]            w_slen;
  logic [4:0]            w_mask;
  logic [5:0]            w_tail;
  logic [MAX_CW_LEN-1:0] w_tail_aligned;

  always_comb begin
    w_slen         = (suffix_len_i > 3'(MAX_SUFFIX_LEN)) ? 3'(MAX_SUFFIX_LEN) : suffix_len_i;
    // Keep only the top w_slen suffix bits so the tail below the codeword stays zero
    w_mask         = ~(5'b11111 >> w_slen);
    w_tail         = {1'b1, suffix_i & w_mask};
    w_tail_aligned = {w_tail, {MAX_PREFIX{1'b0}}};
    codeword_o     = w_tail_aligned >> prefix_i;
    len_o          = {1'b0, prefix_i} + 5'd1 + {2'b00, w_slen};
  end

endmodule

`default_nettype wire

// File: rtl/level_vlc_packer.sv
// ============================================================================
// Module : level_vlc_packer
// Brief  : Packs variable-length codewords MSB-first into 16-bit words.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module level_vlc_packer
  import cavlc_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  level_vlc_packer_if.slave   bus
);

  logic [ACC_W-1:0]      acc_q, acc_d, w_acc_shift, w_cw_ext;
  logic [5:0]            bitcnt_q, bitcnt_d, w_bc_shift;
  logic [COUNT_W-1:0]    wcnt_q, wcnt_d;
  packer_state_t         state_q, state_d;
  logic                  done_q, done_d;

  logic [MAX_CW_LEN-1:0] w_cw;
  logic [4:0]            w_len;
  logic                  w_in_ready, w_flush_ready, w_out_valid, w_out_last;
  logic                  w_in_acc, w_out_acc, w_flush_acc;

  level_codeword_gen u_cw_gen (
    .prefix_i     (bus.Prefix),
    .suffix_i     (bus.Suffix),
    .suffix_len_i (bus.SuffixLen),
    .codeword_o   (w_cw),
    .len_o        (w_len)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= PACK;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_q    <= '0;
      bitcnt_q <= '0;
      wcnt_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      bitcnt_q <= bitcnt_d;
      wcnt_q   <= wcnt_d;
    end
  end

  always_comb begin
    w_in_ready    = (state_q == PACK) && (bitcnt_q <= 6'(IN_THRESH)) && !Reset;
    w_flush_ready = (state_q == PACK) && !Reset;
    w_out_valid   = (bitcnt_q >= 6'(OUT_W)) || ((state_q == FLUSH) && (bitcnt_q != 6'd0));
    w_out_last    = w_out_valid && (state_q == FLUSH) && (bitcnt_q <= 6'(OUT_W));
  end

  always_comb begin
    w_in_acc    = bus.InValid && w_in_ready;
    w_out_acc   = w_out_valid && bus.OutReady;
    w_flush_acc = bus.Flush && w_flush_ready;

    w_acc_shift = acc_q;
    w_bc_shift  = bitcnt_q;
    wcnt_d      = wcnt_q;
    if (w_out_acc) begin
      w_acc_shift = acc_q << OUT_W;
      w_bc_shift  = (bitcnt_q >= 6'(OUT_W)) ? (bitcnt_q - 6'(OUT_W)) : 6'd0;
      wcnt_d      = wcnt_q + 1'b1;
    end

    // Insert position follows the post-shift fill level
    w_cw_ext = {w_cw, {(ACC_W - MAX_CW_LEN){1'b0}}};
    acc_d    = w_acc_shift;
    bitcnt_d = w_bc_shift;
    if (w_in_acc) begin
      acc_d    = w_acc_shift | (w_cw_ext >> w_bc_shift);
      bitcnt_d = w_bc_shift + {1'b0, w_len};
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      PACK: begin
        if (w_flush_acc) begin
          if (bitcnt_d == 6'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if ((w_out_acc && w_out_last) || (bitcnt_q == 6'd0)) begin
          state_d = PACK;
          done_d  = 1'b1;
        end
      end
      default: state_d = PACK;
    endcase
  end

  assign bus.InReady    = w_in_ready;
  assign bus.FlushReady = w_flush_ready;
  assign bus.FlushDone  = done_q;
  assign bus.OutValid   = w_out_valid;
  assign bus.OutWord    = acc_q[ACC_W-1 -: OUT_W];
  assign bus.OutLast    = w_out_last;
  assign bus.WordCount  = wcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_level_vlc_packer.sv
// ============================================================================
// Module : tb_level_vlc_packer
// Brief  : Scoreboard bench for level_vlc_packer (bit-stream reference model).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_level_vlc_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  level_vlc_packer_if #(.COUNT_W(16)) bus ();

  level_vlc_packer #(.COUNT_W(16)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  bit          mbits[$];
  int          mcount = 0;
  bit          flushing = 1'b0;
  bit          done_pend = 1'b0;
  logic [15:0] exp_w;
  bit          exp_l;
  bit          new_pend;

  function automatic void model_push(input logic [3:0] p, input logic [4:0] s,
                                     input logic [2:0] l);
    int          sl;
    logic [15:0] w;
    sl = (l > 3'd5) ? 5 : int'(l);
    for (int i = 0; i < int'(p); i++) mbits.push_back(1'b0);
    mbits.push_back(1'b1);
    for (int i = 0; i < sl; i++) mbits.push_back(s[4-i]);
    while (mbits.size() >= 16) begin
      for (int i = 0; i < 16; i++) w[15-i] = mbits.pop_front();
      exp_q.push_back(w);
    end
  endfunction

  function automatic void model_flush();
    logic [15:0] w;
    int          n;
    if (mbits.size() > 0) begin
      w = 16'h0000;
      n = mbits.size();
      for (int i = 0; i < n; i++) w[15-i] = mbits.pop_front();
      exp_q.push_back(w);
    end
  endfunction

  // Monitor: values seen at negedge are the ones the next posedge acts on
  always @(negedge clk) begin
    n_vec++;
    if (bus.FlushDone !== done_pend) begin
      n_err++;
      $display("FAIL flush_done: got %b want %b at %0t", bus.FlushDone, done_pend, $time);
    end
    n_vec++;
    if (bus.WordCount !== 16'(mcount)) begin
      n_err++;
      $display("FAIL word_count: got %0d want %0d at %0t", bus.WordCount, mcount, $time);
    end
    n_vec++;
    if (bus.OutValid !== (exp_q.size() != 0)) begin
      n_err++;
      $display("FAIL out_valid: got %b want %b at %0t", bus.OutValid, (exp_q.size() != 0), $time);
    end
    if (rst) begin
      exp_q.delete();
      mbits.delete();
      mcount    = 0;
      flushing  = 1'b0;
      done_pend = 1'b0;
    end else begin
      new_pend = 1'b0;
      if (bus.OutValid && bus.OutReady) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_word: got unexpected %h want none at %0t", bus.OutWord, $time);
        end else begin
          exp_w = exp_q.pop_front();
          exp_l = flushing && (exp_q.size() == 0);
          if (bus.OutWord !== exp_w || bus.OutLast !== exp_l) begin
            n_err++;
            $display("FAIL out_word: got %h last %b want %h last %b at %0t",
                     bus.OutWord, bus.OutLast, exp_w, exp_l, $time);
          end
          mcount++;
          if (exp_l) begin
            flushing = 1'b0;
            new_pend = 1'b1;
          end
        end
      end
      if (bus.InValid && bus.InReady) model_push(bus.Prefix, bus.Suffix, bus.SuffixLen);
      if (bus.Flush && bus.FlushReady) begin
        model_flush();
        if (exp_q.size() == 0) new_pend = 1'b1;
        else flushing = 1'b1;
      end
      done_pend = new_pend;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cw(input logic [3:0] p, input logic [4:0] s, input logic [2:0] l,
                         input logic fl);
    int t = 0;
    bit ok = 1'b0;
    bus.InValid = 1'b1; bus.Prefix = p; bus.Suffix = s; bus.SuffixLen = l; bus.Flush = fl;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = bus.InReady;
      tick();
      t++;
    end
    bus.InValid = 1'b0;
    bus.Flush   = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_cw: got no InReady want accept within 50 cycles");
    end
  endtask

  task automatic do_flush();
    int t = 0;
    bit ok = 1'b0;
    bus.Flush = 1'b1;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = bus.FlushReady;
      tick();
      t++;
    end
    bus.Flush = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL do_flush: got no FlushReady want accept within 100 cycles");
    end
  endtask

  task automatic wait_done();
    int t = 0;
    bit ok = 1'b0;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = bus.FlushDone;
      tick();
      t++;
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL wait_done: got no FlushDone want pulse within 100 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_vec++;
    if (bus.InReady !== 1'b0 || bus.FlushReady !== 1'b0 || bus.OutValid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: got rdy %b frdy %b vld %b want 0 0 0",
               bus.InReady, bus.FlushReady, bus.OutValid);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.InReady !== 1'b1 || bus.FlushReady !== 1'b1 || bus.OutLast !== 1'b0 ||
        bus.WordCount !== 16'd0) begin
      n_err++;
      $display("FAIL reset_after: got rdy %b frdy %b last %b cnt %0d want 1 1 0 0",
               bus.InReady, bus.FlushReady, bus.OutLast, bus.WordCount);
    end
    tick();
  endtask

  task automatic test_ones();
    for (int i = 0; i < 16; i++) send_cw(4'd0, 5'd0, 3'd0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    n_vec++;
    if (bus.WordCount !== 16'd1 || bus.OutValid !== 1'b0) begin
      n_err++;
      $display("FAIL ones: got cnt %0d vld %b want 1 0", bus.WordCount, bus.OutValid);
    end
    tick();
  endtask

  task automatic test_flush_short();
    send_cw(4'd3, 5'b10100, 3'd3, 1'b0);
    do_flush();
    @(negedge clk);
    n_vec++;
    if (bus.OutValid !== 1'b1 || bus.OutWord !== 16'h1A00 || bus.OutLast !== 1'b1) begin
      n_err++;
      $display("FAIL flush_short: got vld %b word %h last %b want 1 1a00 1",
               bus.OutValid, bus.OutWord, bus.OutLast);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (bus.FlushDone !== 1'b1 || bus.FlushReady !== 1'b1) begin
      n_err++;
      $display("FAIL flush_short_done: got done %b frdy %b want 1 1", bus.FlushDone, bus.FlushReady);
    end
    tick();
  endtask

  task automatic test_flush_same_cycle();
    send_cw(4'd15, 5'b11111, 3'd5, 1'b1);
    wait_done();
    @(negedge clk);
    n_vec++;
    if (bus.WordCount !== 16'd4) begin
      n_err++;
      $display("FAIL flush_same_cycle: got cnt %0d want 4", bus.WordCount);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    bus.OutReady = 1'b0;
    bus.InValid = 1'b1; bus.Prefix = 4'd15; bus.Suffix = 5'b11111; bus.SuffixLen = 3'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.InReady) acc++;
      if (i >= 1) begin
        n_vec++;
        if (bus.OutWord !== 16'h0001) begin
          n_err++;
          $display("FAIL bp_hold: got %h want 0001 (cycle %0d)", bus.OutWord, i);
        end
      end
      tick();
    end
    n_vec++;
    if (acc != 2 || bus.InReady !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accept: got %0d accepts rdy %b want 2 0", acc, bus.InReady);
    end
    bus.OutReady = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.InReady !== 1'b0 || bus.OutWord !== 16'h0001) begin
      n_err++;
      $display("FAIL bp_release: got rdy %b word %h want 0 0001", bus.InReady, bus.OutWord);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (bus.InReady !== 1'b1 || bus.OutWord !== 16'hF800) begin
      n_err++;
      $display("FAIL bp_resume: got rdy %b word %h want 1 f800", bus.InReady, bus.OutWord);
    end
    tick();
    repeat (6) tick();
    bus.InValid = 1'b0;
    do_flush();
    wait_done();
  endtask

  task automatic test_empty_flush();
    do_flush();
    @(negedge clk);
    n_vec++;
    if (bus.OutValid !== 1'b0 || bus.FlushDone !== 1'b1 || bus.FlushReady !== 1'b1) begin
      n_err++;
      $display("FAIL empty_flush: got vld %b done %b frdy %b want 0 1 1",
               bus.OutValid, bus.FlushDone, bus.FlushReady);
    end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    bus.OutReady = 1'b0;
    send_cw(4'd15, 5'b11110, 3'd4, 1'b0);
    do_flush();
    @(negedge clk);
    n_vec++;
    if (bus.OutValid !== 1'b1 || bus.InReady !== 1'b0 || bus.FlushReady !== 1'b0) begin
      n_err++;
      $display("FAIL mid_flush: got vld %b rdy %b frdy %b want 1 0 0",
               bus.OutValid, bus.InReady, bus.FlushReady);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.OutReady = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.OutValid !== 1'b0 || bus.WordCount !== 16'd0 || bus.FlushDone !== 1'b0 ||
        bus.InReady !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_flush: got vld %b cnt %0d done %b rdy %b want 0 0 0 1",
               bus.OutValid, bus.WordCount, bus.FlushDone, bus.InReady);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.InValid   = ($urandom_range(0, 9) < 7);
      bus.Prefix    = 4'($urandom_range(0, 15));
      bus.Suffix    = 5'($urandom_range(0, 31));
      bus.SuffixLen = 3'($urandom_range(0, 7));
      bus.OutReady  = ($urandom_range(0, 9) < 6);
      bus.Flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.InValid  = 1'b0;
    bus.Flush    = 1'b0;
    bus.OutReady = 1'b1;
    do_flush();
    wait_done();
    repeat (2) tick();
    n_vec++;
    if (exp_q.size() != 0 || mbits.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: got %0d words %0d bits left want 0 0", exp_q.size(), mbits.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.InValid = 1'b0; bus.Prefix = 4'd0; bus.Suffix = 5'd0; bus.SuffixLen = 3'd0;
    bus.Flush = 1'b0; bus.OutReady = 1'b1;
    test_reset();
    test_ones();
    test_flush_short();
    test_flush_same_cycle();
    test_back_to_back();
    test_empty_flush();
    test_reset_mid_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
